// File: rtl/bus_arbiter_rr.sv
// Round-robin common-bus arbiter: one processor owns the bus at a time, and while it
// does, a second arbiter hands the snoop-response slot to a cache or to memory.
module bus_arbiter_rr #(
    parameter int NUM_PROC  = 8,
    parameter int NUM_SNOOP = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PROC-1:0]         Com_Bus_Req_proc,
    input  logic [NUM_SNOOP-1:0]        Com_Bus_Req_snoop,
    input  logic                        Mem_snoop_req,
    output logic [NUM_PROC-1:0]         Com_Bus_Gnt_proc,
    output logic [NUM_SNOOP-1:0]        Com_Bus_Gnt_snoop,
    output logic                        Mem_snoop_gnt,
    output logic [$clog2(NUM_PROC)-1:0] Gnt_id_proc,
    output logic                        Bus_busy
);
    localparam int PW = $clog2(NUM_PROC);
    localparam int SW = (NUM_SNOOP > 1) ? $clog2(NUM_SNOOP) : 1;

    typedef enum logic {
        P_IDLE  = 1'b0,
        P_OWNED = 1'b1
    } p_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CACHE = 2'd1,
        S_MEM   = 2'd2
    } s_state_t;

    // Anything other than a clean 1 (X, Z, 0) counts as "not requesting".
    function automatic logic [NUM_PROC-1:0] clean_proc(input logic [NUM_PROC-1:0] v);
        logic [NUM_PROC-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            r[i] = (v[i] === 1'b1);
        end
        return r;
    endfunction

    function automatic logic [NUM_SNOOP-1:0] clean_snoop(input logic [NUM_SNOOP-1:0] v);
        logic [NUM_SNOOP-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SNOOP; i++) begin
            r[i] = (v[i] === 1'b1);
        end
        return r;
    endfunction

    // Returns {found, index}: the set bit closest to ptr going upward with wrap.
    function automatic logic [PW:0] rr_pick_proc(input logic [NUM_PROC-1:0] req,
                                                 input logic [PW-1:0]       ptr);
        logic [PW:0] res;
        int          best_d;
        int          d;
        res    = '0;
        best_d = NUM_PROC;
        for (int i = 0; i < NUM_PROC; i++) begin
            d = i - int'(ptr);
            if (d < 0) begin
                d = d + NUM_PROC;
            end else begin
                d = d;
            end
            if (req[i] && (d < best_d)) begin
                best_d = d;
                res    = {1'b1, PW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [SW:0] rr_pick_snoop(input logic [NUM_SNOOP-1:0] req,
                                                  input logic [SW-1:0]        ptr);
        logic [SW:0] res;
        int          best_d;
        int          d;
        res    = '0;
        best_d = NUM_SNOOP;
        for (int i = 0; i < NUM_SNOOP; i++) begin
            d = i - int'(ptr);
            if (d < 0) begin
                d = d + NUM_SNOOP;
            end else begin
                d = d;
            end
            if (req[i] && (d < best_d)) begin
                best_d = d;
                res    = {1'b1, SW'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [NUM_PROC-1:0]  preq_s;
    logic [NUM_PROC-1:0]  pcand_s;
    logic [NUM_PROC-1:0]  pgnt_r;
    logic [NUM_PROC-1:0]  pgnt_n_s;
    logic [PW-1:0]        pid_r;
    logic [PW-1:0]        pid_n_s;
    logic [PW-1:0]        pptr_r;
    logic [PW-1:0]        pptr_n_s;
    logic [PW:0]          ppick_s;
    logic                 phold_s;
    p_state_t             p_state_r;
    p_state_t             p_state_n_s;
    logic                 busy_r;
    logic                 busy_n_s;

    logic [NUM_SNOOP-1:0] sreq_s;
    logic [NUM_SNOOP-1:0] scand_s;
    logic [NUM_SNOOP-1:0] sgnt_r;
    logic [NUM_SNOOP-1:0] sgnt_n_s;
    logic [SW-1:0]        sptr_r;
    logic [SW-1:0]        sptr_n_s;
    logic [SW:0]          spick_s;
    logic                 shold_s;
    logic                 sarb_s;
    logic                 smem_ok_s;
    logic                 mreq_s;
    logic                 mgnt_r;
    logic                 mgnt_n_s;
    s_state_t             s_state_r;
    s_state_t             s_state_n_s;

    assign preq_s = clean_proc(Com_Bus_Req_proc);
    assign sreq_s = clean_snoop(Com_Bus_Req_snoop);
    assign mreq_s = (Mem_snoop_req === 1'b1);

    // Processor ownership: hold while the owner requests, else hand over with no gap.
    always_comb begin
        p_state_n_s = P_IDLE;
        pgnt_n_s    = '0;
        pid_n_s     = '0;
        pptr_n_s    = pptr_r;
        pcand_s     = preq_s;
        phold_s     = 1'b0;
        case (p_state_r)
            P_IDLE: begin
                pcand_s = preq_s;
                phold_s = 1'b0;
            end
            P_OWNED: begin
                pcand_s = preq_s & ~pgnt_r;
                phold_s = |(preq_s & pgnt_r);
            end
            default: begin
                pcand_s = '0;
                phold_s = 1'b0;
            end
        endcase
        ppick_s = rr_pick_proc(pcand_s, pptr_r);
        if (phold_s) begin
            p_state_n_s = P_OWNED;
            pgnt_n_s    = pgnt_r;
            pid_n_s     = pid_r;
        end else if (ppick_s[PW]) begin
            p_state_n_s           = P_OWNED;
            pgnt_n_s[ppick_s[PW-1:0]] = 1'b1;
            pid_n_s               = ppick_s[PW-1:0];
            pptr_n_s              = (ppick_s[PW-1:0] == PW'(NUM_PROC - 1)) ? '0
                                                                          : ppick_s[PW-1:0] + PW'(1);
        end else begin
            p_state_n_s = P_IDLE;
            pgnt_n_s    = '0;
            pid_n_s     = '0;
        end
    end

    assign busy_n_s = |pgnt_n_s;

    // Snoop slot: caches win only at arbitration time; everything clears with the bus owner.
    always_comb begin
        s_state_n_s = S_IDLE;
        sgnt_n_s    = '0;
        mgnt_n_s    = 1'b0;
        sptr_n_s    = sptr_r;
        scand_s     = sreq_s;
        shold_s     = 1'b0;
        sarb_s      = 1'b0;
        smem_ok_s   = 1'b0;
        case (s_state_r)
            S_IDLE: begin
                sarb_s    = busy_r;
                smem_ok_s = 1'b1;
            end
            S_CACHE: begin
                scand_s   = sreq_s & ~sgnt_r;
                shold_s   = |(sreq_s & sgnt_r);
                sarb_s    = 1'b1;
                smem_ok_s = 1'b1;
            end
            S_MEM: begin
                shold_s   = mreq_s;
                sarb_s    = 1'b1;
                smem_ok_s = 1'b0;
            end
            default: begin
                sarb_s    = 1'b0;
                smem_ok_s = 1'b0;
            end
        endcase
        spick_s = rr_pick_snoop(scand_s, sptr_r);
        if (!busy_n_s) begin
            s_state_n_s = S_IDLE;
        end else if (shold_s) begin
            s_state_n_s = s_state_r;
            sgnt_n_s    = sgnt_r;
            mgnt_n_s    = mgnt_r;
        end else if (sarb_s && spick_s[SW]) begin
            s_state_n_s               = S_CACHE;
            sgnt_n_s[spick_s[SW-1:0]] = 1'b1;
            sptr_n_s                  = (spick_s[SW-1:0] == SW'(NUM_SNOOP - 1)) ? '0
                                                                            : spick_s[SW-1:0] + SW'(1);
        end else if (sarb_s && smem_ok_s && mreq_s) begin
            s_state_n_s = S_MEM;
            mgnt_n_s    = 1'b1;
        end else begin
            s_state_n_s = S_IDLE;
        end
    end

    // State, pointers and every output are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_state_r <= P_IDLE;
            pgnt_r    <= '0;
            pid_r     <= '0;
            pptr_r    <= '0;
            busy_r    <= 1'b0;
            s_state_r <= S_IDLE;
            sgnt_r    <= '0;
            sptr_r    <= '0;
            mgnt_r    <= 1'b0;
        end else begin
            p_state_r <= p_state_n_s;
            pgnt_r    <= pgnt_n_s;
            pid_r     <= pid_n_s;
            pptr_r    <= pptr_n_s;
            busy_r    <= busy_n_s;
            s_state_r <= s_state_n_s;
            sgnt_r    <= sgnt_n_s;
            sptr_r    <= sptr_n_s;
            mgnt_r    <= mgnt_n_s;
        end
    end

    assign Com_Bus_Gnt_proc  = pgnt_r;
    assign Com_Bus_Gnt_snoop = sgnt_r;
    assign Mem_snoop_gnt     = mgnt_r;
    assign Gnt_id_proc       = pid_r;
    assign Bus_busy          = busy_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic, all compared
// cycle by cycle against an owner/pointer reference model.
module tb_bus_arbiter_rr;
    localparam int NP      = 8;
    localparam int NS      = 4;
    localparam int SN_NONE = -1;
    localparam int SN_MEM  = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] Com_Bus_Req_proc;
    logic [NS-1:0] Com_Bus_Req_snoop;
    logic          Mem_snoop_req;
    logic [NP-1:0] Com_Bus_Gnt_proc;
    logic [NS-1:0] Com_Bus_Gnt_snoop;
    logic          Mem_snoop_gnt;
    logic [2:0]    Gnt_id_proc;
    logic          Bus_busy;

    int total = 0;
    int bad   = 0;

    // reference model: owner indices (-1 = none) and next-search pointers
    int m_owner = -1;
    int m_ptr   = 0;
    int m_sown  = SN_NONE;
    int m_sptr  = 0;

    logic [NP-1:0] rp;
    logic [NS-1:0] rs;
    logic          rm;
    logic          rr;
    int            held;
    int            last_id;
    int            rot[$];

    bus_arbiter_rr #(.NUM_PROC(NP), .NUM_SNOOP(NS)) dut (
        .clk               (clk),
        .rst               (rst),
        .Com_Bus_Req_proc  (Com_Bus_Req_proc),
        .Com_Bus_Req_snoop (Com_Bus_Req_snoop),
        .Mem_snoop_req     (Mem_snoop_req),
        .Com_Bus_Gnt_proc  (Com_Bus_Gnt_proc),
        .Com_Bus_Gnt_snoop (Com_Bus_Gnt_snoop),
        .Mem_snoop_gnt     (Mem_snoop_gnt),
        .Gnt_id_proc       (Gnt_id_proc),
        .Bus_busy          (Bus_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // First requester at or after ptr (wrapping), skipping the current owner.
    task automatic model_step(input logic r, input logic [NP-1:0] p,
                              input logic [NS-1:0] s, input logic m);
        bit was_busy;
        bit keep;
        int nxt;
        int c;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sown  = SN_NONE;
            m_sptr  = 0;
            return;
        end
        was_busy = (m_owner >= 0);
        if (!(m_owner >= 0 && p[m_owner])) begin
            nxt = -1;
            for (int k = 0; k < NP; k++) begin
                c = (m_ptr + k) % NP;
                if (nxt < 0 && c != m_owner && p[c]) nxt = c;
            end
            m_owner = nxt;
            if (nxt >= 0) m_ptr = (nxt + 1) % NP;
        end
        keep = (m_sown == SN_NONE && !was_busy) ||
               (m_sown == SN_MEM && m) ||
               (m_sown >= 0 && m_sown < NS && s[m_sown]);
        if (m_owner < 0) begin
            m_sown = SN_NONE;
        end else if (!keep) begin
            nxt = -1;
            for (int k = 0; k < NS; k++) begin
                c = (m_sptr + k) % NS;
                if (nxt < 0 && c != m_sown && s[c]) nxt = c;
            end
            if (nxt >= 0) begin
                m_sown = nxt;
                m_sptr = (nxt + 1) % NS;
            end else if (m && m_sown != SN_MEM) begin
                m_sown = SN_MEM;
            end else begin
                m_sown = SN_NONE;
            end
        end
    endtask

    task automatic check_model();
        logic [NP-1:0] eg;
        logic [NS-1:0] es;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        es = (m_sown >= 0 && m_sown < NS) ? (4'd1 << m_sown) : 4'd0;
        chk("gnt_proc",  32'(Com_Bus_Gnt_proc),  32'(eg));
        chk("gnt_snoop", 32'(Com_Bus_Gnt_snoop), 32'(es));
        chk("mem_gnt",   32'(Mem_snoop_gnt),     (m_sown == SN_MEM) ? 32'd1 : 32'd0);
        chk("gnt_id",    32'(Gnt_id_proc),       (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("bus_busy",  32'(Bus_busy),          (m_owner >= 0) ? 32'd1 : 32'd0);
    endtask

    task automatic step(input logic r, input logic [NP-1:0] p,
                        input logic [NS-1:0] s, input logic m);
        rst               = r;
        Com_Bus_Req_proc  = p;
        Com_Bus_Req_snoop = s;
        Mem_snoop_req     = m;
        @(posedge clk);
        model_step(r, p, s, m);
        #1;
        check_model();
    endtask

    initial begin
        // reset state
        step(1'b1, 8'h00, 4'h0, 1'b0);
        step(1'b1, 8'hFF, 4'hF, 1'b1);
        chk("rst_busy", 32'(Bus_busy), 32'd0);
        chk("rst_gnt", 32'(Com_Bus_Gnt_proc), 32'd0);

        // fairness: all request, each owner drops after two cycles of ownership
        held    = 0;
        last_id = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            rp = 8'hFF;
            if (m_owner >= 0 && held >= 2) rp[m_owner] = 1'b0;
            step(1'b0, rp, 4'h0, 1'b0);
            chk("fair_busy", 32'(Bus_busy), 32'd1);
            if (int'(Gnt_id_proc) != last_id) begin
                rot.push_back(int'(Gnt_id_proc));
                last_id = int'(Gnt_id_proc);
                held    = 1;
            end else begin
                held++;
            end
        end
        chk("fair_len", (rot.size() >= 9) ? 32'd1 : 32'd0, 32'd1);
        for (int k = 0; k < 9 && k < rot.size(); k++) begin
            chk("fair_rot", 32'(rot[k]), 32'(k % 8));
        end

        // wrap-around: 7 releases with 2 and 5 pending
        step(1'b1, 8'h00, 4'h0, 1'b0);
        step(1'b0, 8'h80, 4'h0, 1'b0);
        chk("wrap_own7", 32'(Gnt_id_proc), 32'd7);
        step(1'b0, 8'h24, 4'h0, 1'b0);
        chk("wrap_id2", 32'(Gnt_id_proc), 32'd2);
        chk("wrap_gnt2", 32'(Com_Bus_Gnt_proc), 32'h04);

        // simultaneous snoop requests while proc 3 owns the bus
        step(1'b1, 8'h00, 4'h0, 1'b0);
        step(1'b0, 8'h08, 4'h0, 1'b0);
        chk("snp_own3", 32'(Gnt_id_proc), 32'd3);
        step(1'b0, 8'h08, 4'b0101, 1'b1);
        chk("snp_first0", 32'(Com_Bus_Gnt_snoop), 32'h1);
        chk("snp_first_mem", 32'(Mem_snoop_gnt), 32'd0);
        step(1'b0, 8'h08, 4'b0100, 1'b1);
        chk("snp_then2", 32'(Com_Bus_Gnt_snoop), 32'h4);
        step(1'b0, 8'h08, 4'b0000, 1'b1);
        chk("snp_then_mem", 32'(Mem_snoop_gnt), 32'd1);

        // memory is not pre-empted by a later cache request
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 8'h08, 4'b0010, 1'b1);
            chk("mem_hold_snoop", 32'(Com_Bus_Gnt_snoop), 32'h0);
            chk("mem_hold_gnt", 32'(Mem_snoop_gnt), 32'd1);
        end
        step(1'b0, 8'h08, 4'b0010, 1'b0);
        chk("mem_rel_snoop1", 32'(Com_Bus_Gnt_snoop), 32'h2);
        chk("mem_rel_gnt", 32'(Mem_snoop_gnt), 32'd0);

        // owner drop clears the memory grant at the same edge
        step(1'b0, 8'h08, 4'b0000, 1'b1);
        chk("drop_pre_mem", 32'(Mem_snoop_gnt), 32'd1);
        step(1'b0, 8'h00, 4'b0000, 1'b1);
        chk("drop_busy", 32'(Bus_busy), 32'd0);
        chk("drop_mem", 32'(Mem_snoop_gnt), 32'd0);

        // reset while proc 5 holds the bus
        step(1'b1, 8'h00, 4'h0, 1'b0);
        step(1'b0, 8'h20, 4'h0, 1'b0);
        chk("rst5_own", 32'(Gnt_id_proc), 32'd5);
        step(1'b1, 8'h20, 4'h0, 1'b0);
        chk("rst5_gnt", 32'(Com_Bus_Gnt_proc), 32'd0);
        chk("rst5_id", 32'(Gnt_id_proc), 32'd0);
        step(1'b1, 8'h20, 4'h0, 1'b0);
        step(1'b0, 8'h20, 4'h0, 1'b0);
        chk("rst5_regrant", 32'(Gnt_id_proc), 32'd5);
        chk("rst5_busy", 32'(Bus_busy), 32'd1);

        // random traffic with sticky requests and occasional reset
        rp = 8'h00;
        rs = 4'h0;
        rm = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rp = rp ^ 8'($urandom & $urandom & $urandom);
            rs = rs ^ 4'($urandom & $urandom);
            if ($urandom_range(0, 4) == 0) rm = ~rm;
            rr = ($urandom_range(0, 59) == 0);
            step(rr, rp, rs, rm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
